aes16_dec_scheduler: RTL and testbench

AES16_DEC_SCHEDULER -- requirements
Module: aes16_dec_scheduler

---
 rtl/aes16_dec_scheduler.sv | 134 +++++++++++++
 tb/tb_aes16_dec_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes16_dec_scheduler.sv
// Two-requester round-robin front end for a fixed-latency 16-bit decryption core.
// Registers ciphertext/key to the core, waits LATENCY cycles, holds the plaintext until consumed.
module aes16_dec_scheduler #(
  parameter int unsigned LATENCY   = 4,
  parameter logic [15:0] KEY_RESET = 16'hABCD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  input  logic        key_we,
  input  logic [15:0] key_in,
  output logic [15:0] core_codein,
  output logic [15:0] core_key,
  input  logic [15:0] core_codeout,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_src,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [15:0] key_q, key_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_src_q, out_src_d;
  logic [15:0] core_codein_q, core_codein_d;
  logic [15:0] core_key_q, core_key_d;

  logic grant_vld;
  logic grant_idx;

  always_comb begin
    grant_vld = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_idx = ~last_grant_q;
    end else begin
      grant_idx = req1_valid;
    end
  end

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_src_d     = out_src_q;
    core_codein_d = core_codein_q;
    core_key_d    = core_key_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;

    // Transfers sample key_q before this edge's write, so a coincident write waits a turn.
    if (key_we) begin
      key_d = key_in;
    end

    case (state_q)
      IDLE: begin
        if (!rst && grant_vld) begin
          req0_ready    = ~grant_idx;
          req1_ready    = grant_idx;
          core_codein_d = grant_idx ? req1_data : req0_data;
          core_key_d    = key_q;
          out_src_d     = grant_idx;
          last_grant_d  = grant_idx;
          cnt_d         = CNT_INIT;
          state_d       = RUN;
        end
      end
      RUN: begin
        if (cnt_q == 8'd0) begin
          out_data_d  = core_codeout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      key_q         <= KEY_RESET;
      last_grant_q  <= 1'b1;
      cnt_q         <= 8'd0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 16'd0;
      out_src_q     <= 1'b0;
      core_codein_q <= 16'd0;
      core_key_q    <= KEY_RESET;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      core_codein_q <= core_codein_d;
      core_key_q    <= core_key_d;
    end
  end

  assign core_codein = core_codein_q;
  assign core_key    = core_key_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_aes16_dec_scheduler.sv
// Directed bench for aes16_dec_scheduler; the core is modelled as codein ^ key.
// Main instance uses LATENCY=4; two extra instances share inputs for LATENCY=1 and 255.
module tb_aes16_dec_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_data, req1_data;
  logic        key_we;
  logic [15:0] key_in;
  logic        out_ready;

  logic        req0_ready, req1_ready, out_valid, out_src, busy;
  logic [15:0] core_codein, core_key, out_data, core_codeout;

  logic        a_r0, a_r1, a_ov, a_os, a_busy;
  logic [15:0] a_ci, a_ck, a_od, a_co;
  logic        b_r0, b_r1, b_ov, b_os, b_busy;
  logic [15:0] b_ci, b_ck, b_od, b_co;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign core_codeout = core_codein ^ core_key;
  assign a_co         = a_ci ^ a_ck;
  assign b_co         = b_ci ^ b_ck;

  aes16_dec_scheduler #(.LATENCY(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .key_we(key_we), .key_in(key_in),
    .core_codein(core_codein), .core_key(core_key), .core_codeout(core_codeout),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  aes16_dec_scheduler #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(a_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(a_r1),
    .key_we(key_we), .key_in(key_in),
    .core_codein(a_ci), .core_key(a_ck), .core_codeout(a_co),
    .out_valid(a_ov), .out_data(a_od), .out_src(a_os),
    .out_ready(out_ready), .busy(a_busy)
  );

  aes16_dec_scheduler #(.LATENCY(255)) dut_l255 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_r0),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_r1),
    .key_we(key_we), .key_in(key_in),
    .core_codein(b_ci), .core_key(b_ck), .core_codeout(b_co),
    .out_valid(b_ov), .out_data(b_od), .out_src(b_os),
    .out_ready(out_ready), .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; key_we = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 16'h1111; req1_data = 16'h2222;
    key_we = 1'b0; key_in = 16'h0; out_ready = 1'b1;
    step(); step();
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, out_src} !== 3'b000 || out_data !== 16'h0 ||
        core_codein !== 16'h0 || core_key !== 16'hABCD) begin
      errors++;
      $display("FAIL reset_vals: busy=%b ov=%b src=%b od=%h ci=%h ck=%h want 0 0 0 0000 0000 abcd",
               busy, out_valid, out_src, out_data, core_codein, core_key);
    end
  endtask

  task automatic test_basic();
    do_reset();
    req0_valid = 1'b1; req0_data = 16'h1234; out_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL basic_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0;
    checks++;
    if (core_codein !== 16'h1234 || core_key !== 16'hABCD || busy !== 1'b1) begin
      errors++; $display("FAIL basic_core_in: ci=%h ck=%h busy=%b want 1234 abcd 1", core_codein, core_key, busy);
    end
    step(); step(); step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early: out_valid=%b at T+3 want 0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hB9F9 || out_src !== 1'b0) begin
      errors++; $display("FAIL basic_result: ov=%b od=%h src=%b want 1 b9f9 0", out_valid, out_data, out_src);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic exp;
    logic [15:0] exp_ci;
    int n;
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 16'h1111; req1_data = 16'h2222; out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp = g[0];
      exp_ci = exp ? 16'h2222 : 16'h1111;
      #1;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin step(); n++; end
      checks++;
      if (req0_ready !== !exp || req1_ready !== exp) begin
        errors++; $display("FAIL rr_grant%0d: got %b%b want %b%b", g, req0_ready, req1_ready, !exp, exp);
      end
      step();
      checks++;
      if (core_codein !== exp_ci) begin
        errors++; $display("FAIL rr_codein%0d: got %h want %h", g, core_codein, exp_ci);
      end
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
      checks++;
      if (out_valid !== 1'b1 || out_src !== exp || out_data !== (exp_ci ^ 16'hABCD)) begin
        errors++; $display("FAIL rr_result%0d: ov=%b src=%b od=%h want 1 %b %h", g, out_valid, out_src, out_data, exp, exp_ci ^ 16'hABCD);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    req1_valid = 1'b1; req1_data = 16'h0F0F; out_ready = 1'b0;
    step();
    req0_valid = 1'b1; req0_data = 16'h7777;
    step(); step(); step(); step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hA4C2 || out_src !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold%0d: ov=%b od=%h src=%b rdy=%b%b busy=%b want 1 a4c2 1 00 1",
                 i, out_valid, out_data, out_src, req0_ready, req1_ready, busy);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release: ov=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_key_update();
    do_reset();
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h1234;
    step();
    req0_valid = 1'b0;
    key_we = 1'b1; key_in = 16'h5A5A;
    step();
    key_we = 1'b0;
    step(); step(); step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hB9F9 || core_key !== 16'hABCD) begin
      errors++; $display("FAIL key_inflight: ov=%b od=%h ck=%h want 1 b9f9 abcd", out_valid, out_data, core_key);
    end
    step();
    req1_valid = 1'b1; req1_data = 16'h0000;
    key_we = 1'b1; key_in = 16'h3C3C;
    step();
    req1_valid = 1'b0; key_we = 1'b0;
    checks++;
    if (core_key !== 16'h5A5A) begin
      errors++; $display("FAIL key_coincident: ck=%h want 5a5a", core_key);
    end
    step(); step(); step(); step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h5A5A) begin
      errors++; $display("FAIL key_new_result: ov=%b od=%h want 1 5a5a", out_valid, out_data);
    end
    step();
    req0_valid = 1'b1; req0_data = 16'h0001;
    step();
    req0_valid = 1'b0;
    checks++;
    if (core_key !== 16'h3C3C) begin
      errors++; $display("FAIL key_next: ck=%h want 3c3c", core_key);
    end
    step(); step(); step(); step(); step();
  endtask

  task automatic test_reset_midflight();
    int seen;
    do_reset();
    out_ready = 1'b1;
    key_we = 1'b1; key_in = 16'h5A5A;
    step();
    key_we = 1'b0;
    req0_valid = 1'b1; req0_data = 16'hBEEF;
    step();
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, out_valid, out_src} !== 3'b000 || out_data !== 16'h0 ||
        core_codein !== 16'h0 || core_key !== 16'hABCD) begin
      errors++;
      $display("FAIL midreset_vals: busy=%b ov=%b src=%b od=%h ci=%h ck=%h want 0 0 0 0000 0000 abcd",
               busy, out_valid, out_src, out_data, core_codein, core_key);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midreset_pulse: out_valid seen %0d cycles want 0", seen);
    end
    req1_valid = 1'b1; req1_data = 16'h0000;
    step();
    req1_valid = 1'b0;
    checks++;
    if (core_key !== 16'hABCD) begin
      errors++; $display("FAIL midreset_key: ck=%h want abcd", core_key);
    end
    step(); step(); step(); step(); step();
  endtask

  task automatic test_latency_bounds();
    do_reset();
    out_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h00FF;
    step();
    req0_valid = 1'b0;
    for (int k = 1; k <= 256; k++) begin
      step();
      checks++;
      if (a_ov !== 1'b1 || b_ov !== (k >= 255) || out_valid !== (k >= 4)) begin
        errors++;
        $display("FAIL lat_T+%0d: l1=%b l4=%b l255=%b want 1 %b %b", k, a_ov, out_valid, b_ov, k >= 4, k >= 255);
      end
    end
    checks++;
    if (b_od !== 16'hAB32 || a_od !== 16'hAB32 || b_busy !== 1'b1) begin
      errors++; $display("FAIL lat_data: l1=%h l255=%h busy=%b want ab32 ab32 1", a_od, b_od, b_busy);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (b_ov !== 1'b0 || b_busy !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL lat_release: l255 ov=%b busy=%b l1 busy=%b want 0 0 0", b_ov, b_busy, a_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_key_update();
    test_reset_midflight();
    test_latency_bounds();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
